// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command frame parser.
// State encoding, error codes and the default start-of-frame byte.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] DEF_HEADER = 8'hAA;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte watchdog: clear/enable counter with a combinational expiry strobe.
// Expiry fires while the count sits at TIMEOUT_CYC-1, unless cleared that cycle.
module frame_timeout_cnt #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles header/cmd/len/payload/checksum frames from the UART byte stream.
// Streams payload bytes, then strobes frame_valid or frame_err per frame.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HEADER      = DEF_HEADER,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 20000,
    parameter int         IDX_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic             pl_valid,
    output logic [7:0]       pl_data,
    output logic [IDX_W-1:0] pl_idx,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [7:0]       cmd,
    output logic [IDX_W-1:0] len,
    output logic             busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state_q, state_d;
    logic             rx_prev_q;
    logic             byte_ev;
    logic             tmo_exp;
    logic [7:0]       csum_q, csum_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_d;
    logic [IDX_W-1:0] len_d;
    logic             pl_valid_d;
    logic [7:0]       pl_data_d;
    logic [IDX_W-1:0] pl_idx_d;
    logic             frame_valid_d;
    logic             frame_err_d;
    logic [1:0]       err_code_d;

    // A strobe held high for several cycles still yields one byte
    assign byte_ev = rx_done && !rx_prev_q;
    assign busy    = (state_q != ST_IDLE);

    frame_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (byte_ev || state_q == ST_IDLE),
        .en     (state_q != ST_IDLE),
        .expired(tmo_exp)
    );

    always_comb begin
        state_d       = state_q;
        csum_d        = csum_q;
        cnt_d         = cnt_q;
        cmd_d         = cmd;
        len_d         = len;
        pl_valid_d    = 1'b0;
        pl_data_d     = pl_data;
        pl_idx_d      = pl_idx;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code;
        if (byte_ev) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == HEADER) begin
                        state_d = ST_CMD;
                        csum_d  = '0;
                    end
                end
                ST_CMD: begin
                    cmd_d   = rx_data;
                    csum_d  = csum_q + rx_data;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    len_d  = IDX_W'(rx_data);
                    csum_d = csum_q + rx_data;
                    if (rx_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else if (rx_data == 8'd0) begin
                        state_d = ST_CHK;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    pl_valid_d = 1'b1;
                    pl_data_d  = rx_data;
                    pl_idx_d   = cnt_q;
                    csum_d     = csum_q + rx_data;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == len - 1'b1) begin
                        state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (rx_data == csum_q) begin
                        frame_valid_d = 1'b1;
                        err_code_d    = ERR_NONE;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_exp) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rx_prev_q   <= 1'b0;
            csum_q      <= '0;
            cnt_q       <= '0;
            cmd         <= '0;
            len         <= '0;
            pl_valid    <= 1'b0;
            pl_data     <= '0;
            pl_idx      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            rx_prev_q   <= rx_done;
            csum_q      <= csum_d;
            cnt_q       <= cnt_d;
            cmd         <= cmd_d;
            len         <= len_d;
            pl_valid    <= pl_valid_d;
            pl_data     <= pl_data_d;
            pl_idx      <= pl_idx_d;
            frame_valid <= frame_valid_d;
            frame_err   <= frame_err_d;
            err_code    <= err_code_d;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed and randomized frame stimulus for uart_frame_parser.
// Expected results come from the frames the bench itself builds.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 64;
    localparam int IDX_W   = 8;

    typedef logic [15:0] pl_q_t[$];
    typedef logic [7:0]  by_q_t[$];

    logic             clk;
    logic             rst_n;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic             pl_valid;
    logic [7:0]       pl_data;
    logic [IDX_W-1:0] pl_idx;
    logic             frame_valid;
    logic             frame_err;
    logic [1:0]       err_code;
    logic [7:0]       cmd;
    logic [IDX_W-1:0] len;
    logic             busy;

    int    checks = 0;
    int    errors = 0;
    pl_q_t plq;
    int    fv_cnt;
    int    fe_cnt;
    logic [1:0] ev_code;

    uart_frame_parser #(
        .HEADER     (8'hAA),
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT_CYC(TMO),
        .IDX_W      (IDX_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .pl_valid   (pl_valid),
        .pl_data    (pl_data),
        .pl_idx     (pl_idx),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .cmd        (cmd),
        .len        (len),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (pl_valid) plq.push_back({pl_data, pl_idx});
            if (frame_valid) begin fv_cnt++; ev_code = err_code; end
            if (frame_err) begin fe_cnt++; ev_code = err_code; end
            if (frame_valid || frame_err)
                chk("excl", {30'd0, frame_valid, frame_err},
                    frame_valid ? 32'd2 : 32'd1);
        end
    end

    task automatic clear_mon();
        plq.delete();
        fv_cnt  = 0;
        fe_cnt  = 0;
        ev_code = 2'd0;
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_seq(input by_q_t bs, input int hold);
        foreach (bs[i]) send(bs[i], hold, 1);
    endtask

    task automatic expect_frame(input string tag, input pl_q_t ep,
                                input int efv, input int efe,
                                input logic [1:0] ecode);
        repeat (3) @(negedge clk);
        chk({tag, " pl_n"}, plq.size(), ep.size());
        foreach (ep[i])
            if (i < plq.size()) chk({tag, " pl"}, plq[i], ep[i]);
        chk({tag, " fv_n"}, fv_cnt, efv);
        chk({tag, " fe_n"}, fe_cnt, efe);
        if (efv + efe > 0) chk({tag, " ev_code"}, ev_code, ecode);
        chk({tag, " err_code"}, err_code, ecode);
        chk({tag, " busy"}, busy, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " strobes"}, {pl_valid, frame_valid, frame_err, busy}, 0);
        chk({tag, " data"}, {pl_data, pl_idx, err_code}, 0);
        chk({tag, " cmd_len"}, {cmd, len}, 0);
    endtask

    initial begin
        by_q_t bs;
        pl_q_t ep;
        int    cyc;
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame, with a busy check part way through
        clear_mon();
        send(8'hAA, 1, 1);
        send(8'h01, 1, 1);
        chk("busy_mid", busy, 1);
        send_seq('{8'h02, 8'h10, 8'h20, 8'h33}, 1);
        ep = '{16'h1000, 16'h2001};
        expect_frame("good", ep, 1, 0, 2'd0);
        chk("good cmd", cmd, 8'h01);
        chk("good len", len, 2);

        clear_mon();
        send_seq('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34}, 1);
        expect_frame("badchk", ep, 0, 1, 2'd1);

        clear_mon();
        send_seq('{8'hAA, 8'h05, 8'h00, 8'h05}, 1);
        ep = {};
        expect_frame("zero", ep, 1, 0, 2'd0);
        chk("zero cmd", cmd, 8'h05);
        chk("zero len", len, 0);

        // Over-length: error visible right after the len byte event
        clear_mon();
        send(8'hAA, 1, 1);
        send(8'h01, 1, 1);
        send(8'h11, 1, 0);
        chk("over fe_now", frame_err, 1);
        chk("over code_now", err_code, 2);
        chk("over busy_now", busy, 0);
        expect_frame("over", ep, 0, 1, 2'd2);
        clear_mon();
        send_seq('{8'hAA, 8'h02, 8'h00, 8'h02}, 1);
        expect_frame("after_over", ep, 1, 0, 2'd0);

        clear_mon();
        send_seq('{8'h55, 8'h00, 8'hFF, 8'hAA, 8'h03, 8'h01, 8'h07, 8'h0B}, 1);
        ep = '{16'h0700};
        expect_frame("noise", ep, 1, 0, 2'd0);

        // Timeout counted from the last byte event
        clear_mon();
        send(8'hAA, 1, 1);
        @(negedge clk);
        rx_data = 8'h01;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        cyc = 0;
        while (!frame_err && cyc < TMO + 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo cycles", cyc, TMO);
        ep = {};
        expect_frame("tmo", ep, 0, 1, 2'd3);

        clear_mon();
        send_seq('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33}, 3);
        ep = '{16'h1000, 16'h2001};
        expect_frame("stretch", ep, 1, 0, 2'd0);

        // Reset in the middle of a frame
        send_seq('{8'hAA, 8'h01, 8'h02, 8'h10}, 1);
        clear_mon();
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(negedge clk);
        chk("midrst fe_n", fe_cnt, 0);
        rst_n = 1'b1;
        clear_mon();
        send_seq('{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33}, 1);
        expect_frame("post_rst", ep, 1, 0, 2'd0);

        // Randomized frames: good, bad checksum, over-length
        for (int n = 0; n < 40; n++) begin
            int          kind;
            int          hold;
            int          flen;
            logic [7:0]  c;
            logic [7:0]  sum;
            logic [7:0]  b;
            kind = int'($urandom_range(0, 2));
            hold = int'($urandom_range(1, 3));
            c    = 8'($urandom);
            bs   = {};
            ep   = {};
            for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
                b = 8'($urandom_range(0, 254));
                if (b == 8'hAA) b = 8'h00;
                bs.push_back(b);
            end
            flen = (kind == 2) ? int'($urandom_range(MAX_LEN + 1, 255))
                               : int'($urandom_range(0, MAX_LEN));
            bs.push_back(8'hAA);
            bs.push_back(c);
            bs.push_back(8'(flen));
            sum = c + 8'(flen);
            if (kind != 2) begin
                for (int i = 0; i < flen; i++) begin
                    b = 8'($urandom);
                    bs.push_back(b);
                    ep.push_back({b, 8'(i)});
                    sum = sum + b;
                end
                if (kind == 1) sum = sum ^ 8'($urandom_range(1, 255));
                bs.push_back(sum);
            end
            clear_mon();
            send_seq(bs, hold);
            expect_frame($sformatf("rnd%0d", n), ep,
                         (kind == 0) ? 1 : 0, (kind == 0) ? 0 : 1,
                         (kind == 0) ? 2'd0 : (kind == 1) ? 2'd1 : 2'd2);
            chk($sformatf("rnd%0d cmd", n), cmd, c);
            chk($sformatf("rnd%0d len", n), len, flen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
